// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, classifies each
// full scan as NONE/KEY/MULTI, debounces whole scans and commits hex key events.
module keypad_scan_decoder #(
    parameter int unsigned SCAN_DIV       = 16,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_release
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned STB_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_kind_e;
    typedef enum logic {ST_IDLE, ST_PRESSED} state_e;

    logic [3:0]       row_m, row_s;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       col_idx;
    logic [1:0]       hits, hits_nxt;
    logic [3:0]       cand, cand_nxt;
    res_kind_e        prev_kind, res_kind;
    logic [3:0]       prev_code, res_code;
    logic [STB_W-1:0] stable_cnt, stb_nxt;
    state_e           state;
    logic             sample, scan_end, commit;

    assign sample   = (cnt == CNT_LAST);
    assign scan_end = sample && (col_idx == 2'd3);
    assign commit   = scan_end && (stb_nxt == STB_MAX);

    // Accumulate row hits for the current column; column 0 starts a fresh scan.
    always_comb begin
        hits_nxt = (col_idx == 2'd0) ? 2'd0 : hits;
        cand_nxt = (col_idx == 2'd0) ? 4'd0 : cand;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) begin
                if (hits_nxt == 2'd0)
                    cand_nxt = {2'(r), col_idx};
                if (hits_nxt != 2'd2)
                    hits_nxt = hits_nxt + 2'd1;
            end
        end
    end

    // Classify the finished scan and advance the stability count against the last result.
    always_comb begin
        res_kind = RES_MULTI;
        res_code = 4'd0;
        if (hits_nxt == 2'd0) begin
            res_kind = RES_NONE;
        end else if (hits_nxt == 2'd1) begin
            res_kind = RES_KEY;
            res_code = cand_nxt;
        end
        if (res_kind == prev_kind && res_code == prev_code)
            stb_nxt = (stable_cnt >= STB_MAX) ? STB_MAX : stable_cnt + STB_W'(1);
        else
            stb_nxt = STB_W'(1);
    end

    // Synchronizer, dwell counter and column strobe.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            row_m   <= 4'hF;
            row_s   <= 4'hF;
            cnt     <= '0;
            col_idx <= 2'd0;
            col_out <= 4'b1110;
            hits    <= 2'd0;
            cand    <= 4'd0;
        end else begin
            row_m <= row_in;
            row_s <= row_m;
            if (sample) begin
                cnt     <= '0;
                col_idx <= col_idx + 2'd1;
                col_out <= ~(4'b0001 << (col_idx + 2'd1));
                hits    <= hits_nxt;
                cand    <= cand_nxt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Debounce history, updated once per completed scan.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            prev_kind  <= RES_NONE;
            prev_code  <= 4'd0;
            stable_cnt <= '0;
        end else if (scan_end) begin
            prev_kind  <= res_kind;
            prev_code  <= res_code;
            stable_cnt <= stb_nxt;
        end
    end

    // Commit FSM; MULTI results never move it, which suppresses ghost keys.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (commit) begin
                case (state)
                    ST_IDLE: begin
                        if (res_kind == RES_KEY) begin
                            state     <= ST_PRESSED;
                            key_code  <= res_code;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (res_kind == RES_KEY && res_code != key_code) begin
                            key_code  <= res_code;
                            key_valid <= 1'b1;
                        end else if (res_kind == RES_NONE) begin
                            state       <= ST_IDLE;
                            key_held    <= 1'b0;
                            key_release <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
